// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a load/store unit and the
// memory responder. Signal names keep the responder's port naming so the
// direction is readable from the responder's point of view.
interface mem_responder_if #(
  parameter int DATA_W = 32
);

  logic              mem_req_val_i;
  logic              mem_req_rdy_o;
  logic              mem_req_is_write_i;
  logic [DATA_W-1:0] mem_req_addr_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic              mem_req_is_cas_i;
  logic              mem_rsp_val_o;
  logic              mem_rsp_rdy_i;
  logic [DATA_W-1:0] mem_rsp_data_o;

  // Requester side (LSU or bench).
  modport master (
    output mem_req_val_i, mem_req_is_write_i, mem_req_addr_i,
           mem_req_data_i, mem_req_is_cas_i, mem_rsp_rdy_i,
    input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
  );

  // Responder side.
  modport slave (
    input  mem_req_val_i, mem_req_is_write_i, mem_req_addr_i,
           mem_req_data_i, mem_req_is_cas_i, mem_rsp_rdy_i,
    output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o
  );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves read, write and two-beat compare-and-swap
// requests against an internal word array, one operation in flight, with a
// fixed response latency. A backdoor write port lets benches preload words.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  mem_responder_if.slave           bus,
  input  logic                     init_we_i,
  input  logic [$clog2(DEPTH)-1:0] init_addr_i,
  input  logic [DATA_W-1:0]        init_data_i,
  output logic                     proto_err_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int IDX_LO = $clog2(DATA_W / 8);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAS_WAIT,
    BUSY,
    RSP
  } state_e;

  state_e            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  cas_idx;
  logic [DATA_W-1:0] cas_cmp;
  logic [DATA_W-1:0] rsp_data;
  logic              proto_err;

  logic              req_rdy;
  logic              rsp_val;
  logic              req_fire;
  logic [IDX_W-1:0]  req_idx;
  logic              cas_hit;
  logic              cas_match;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wr_idx;
  logic [DATA_W-1:0] mem_wr_data;

  // Byte offset and bits above the array size do not select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_req_addr_i[DATA_W-1:IDX_LO+IDX_W],
                              bus.mem_req_addr_i[IDX_LO-1:0]};

  assign req_idx   = bus.mem_req_addr_i[IDX_LO +: IDX_W];
  assign req_fire  = bus.mem_req_val_i && req_rdy;
  assign cas_hit   = (state == CAS_WAIT) && req_fire && bus.mem_req_is_cas_i
                     && (req_idx == cas_idx);
  assign cas_match = (mem[cas_idx] == cas_cmp);

  assign bus.mem_req_rdy_o  = req_rdy;
  assign bus.mem_rsp_val_o  = rsp_val;
  assign bus.mem_rsp_data_o = rsp_data;
  assign proto_err_o        = proto_err;

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks execute in.
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_fire) state_nxt = bus.mem_req_is_cas_i ? CAS_WAIT : BUSY;
      end
      CAS_WAIT: begin
        // A matching second beat completes the CAS; anything else aborts it.
        if (req_fire) state_nxt = cas_hit ? BUSY : IDLE;
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RSP;
      end
      RSP: begin
        if (bus.mem_rsp_rdy_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_rdy = 1'b0;
    rsp_val = 1'b0;
    unique case (state)
      IDLE, CAS_WAIT: req_rdy = 1'b1;
      RSP:            rsp_val = 1'b1;
      default: ;
    endcase
  end

  // Select the single array write for this cycle: request write, CAS swap,
  // or the backdoor when the request side is quiet in IDLE.
  always_comb begin
    mem_we      = 1'b0;
    mem_wr_idx  = req_idx;
    mem_wr_data = bus.mem_req_data_i;
    if (state == IDLE) begin
      if (req_fire) begin
        mem_we = !bus.mem_req_is_cas_i && bus.mem_req_is_write_i;
      end else if (init_we_i) begin
        mem_we      = 1'b1;
        mem_wr_idx  = init_addr_i;
        mem_wr_data = init_data_i;
      end
    end else if (cas_hit && cas_match) begin
      mem_we     = 1'b1;
      mem_wr_idx = cas_idx;
    end
  end

  // Word array; reset clears every entry.
  always_ff @(posedge clk_i) begin
    // NOTE: the array is reset explicitly because benches rely on a zeroed
    // memory after reset; this keeps it in flops rather than a RAM macro.
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_wr_idx] <= mem_wr_data;
    end
  end

  // Operation datapath: latency counter, CAS context, response data, error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt       <= '0;
      cas_idx   <= '0;
      cas_cmp   <= '0;
      rsp_data  <= '0;
      proto_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            if (bus.mem_req_is_cas_i) begin
              cas_idx <= req_idx;
              cas_cmp <= bus.mem_req_data_i;
            end else begin
              cnt      <= CNT_LOAD;
              rsp_data <= bus.mem_req_is_write_i ? bus.mem_req_data_i
                                                 : mem[req_idx];
            end
          end
        end
        CAS_WAIT: begin
          if (cas_hit) begin
            cnt      <= CNT_LOAD;
            rsp_data <= DATA_W'(cas_match);
          end else if (req_fire) begin
            proto_err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: backdoor preload, read/write latency,
// address wrap, CAS success/failure, response back-pressure, CAS protocol
// error and reset from the BUSY and RSP states.
module tb_mem_responder;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int BOUND   = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_we;
  logic [7:0]        init_addr;
  logic [DATA_W-1:0] init_data;
  logic              proto_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder_if #(.DATA_W(DATA_W)) bus ();

  mem_responder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .init_we_i  (init_we),
    .init_addr_i(init_addr),
    .init_data_i(init_data),
    .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backdoor write; called at a negedge while the responder is IDLE.
  task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
    init_we   = 1'b1;
    init_addr = idx;
    init_data = data;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  // Present one request beat at a negedge; returns at the negedge after
  // the edge that accepted it.
  task automatic send_beat(input logic we, input logic cas,
                           input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    bus.mem_req_val_i      = 1'b1;
    bus.mem_req_is_write_i = we;
    bus.mem_req_is_cas_i   = cas;
    bus.mem_req_addr_i     = addr;
    bus.mem_req_data_i     = data;
    while (!bus.mem_req_rdy_o && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("req_rdy_wait", {31'b0, bus.mem_req_rdy_o}, 32'd1);
    @(negedge clk);
    bus.mem_req_val_i      = 1'b0;
    bus.mem_req_is_write_i = 1'b0;
    bus.mem_req_is_cas_i   = 1'b0;
  endtask

  // Wait for the response following an acceptance, checking latency,
  // request-side stall and data, then consume it.
  task automatic get_rsp(input string tag, input logic [31:0] exp);
    int lat = 0;
    while (!bus.mem_rsp_val_o && lat < BOUND) begin
      check({tag, "_busy_rdy"}, {31'b0, bus.mem_req_rdy_o}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, LATENCY);
    check({tag, "_data"}, bus.mem_rsp_data_o, exp);
    bus.mem_rsp_rdy_i = 1'b1;
    @(negedge clk);
    bus.mem_rsp_rdy_i = 1'b0;
    check({tag, "_rdy_after"}, {31'b0, bus.mem_req_rdy_o}, 32'd1);
    check({tag, "_val_after"}, {31'b0, bus.mem_rsp_val_o}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp);
    send_beat(1'b0, 1'b0, addr, 32'h0);
    get_rsp(tag, exp);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    check({tag, "_rsp_val"}, {31'b0, bus.mem_rsp_val_o}, 32'd0);
    check({tag, "_req_rdy"}, {31'b0, bus.mem_req_rdy_o}, 32'd1);
    check({tag, "_err"}, {31'b0, proto_err}, 32'd0);
    check({tag, "_rsp_data"}, bus.mem_rsp_data_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int wait_n;
    rst_n                  = 1'b0;
    init_we                = 1'b0;
    init_addr              = '0;
    init_data              = '0;
    bus.mem_req_val_i      = 1'b0;
    bus.mem_req_is_write_i = 1'b0;
    bus.mem_req_is_cas_i   = 1'b0;
    bus.mem_req_addr_i     = '0;
    bus.mem_req_data_i     = '0;
    bus.mem_rsp_rdy_i      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_rdy", {31'b0, bus.mem_req_rdy_o}, 32'd1);
    check("rst_rsp_val", {31'b0, bus.mem_rsp_val_o}, 32'd0);
    check("rst_rsp_data", bus.mem_rsp_data_o, 32'd0);
    check("rst_err", {31'b0, proto_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Backdoor preload then read through the request port.
    bd_write(8'd4, 32'hDEAD_BEEF);
    do_read("bd_read", 32'h10, 32'hDEAD_BEEF);

    // Write, read back, and read through a wrapped address.
    send_beat(1'b1, 1'b0, 32'h20, 32'h1234);
    get_rsp("wr_rsp", 32'h1234);
    do_read("wr_readback", 32'h20, 32'h1234);
    do_read("wrap_read", 32'h20 + 4 * DEPTH, 32'h1234);

    // CAS success, then a failing CAS leaves the swapped value.
    bd_write(8'd8, 32'd5);
    send_beat(1'b0, 1'b1, 32'h20, 32'd5);
    check("cas_beat0_rdy", {31'b0, bus.mem_req_rdy_o}, 32'd1);
    send_beat(1'b0, 1'b1, 32'h20, 32'd9);
    get_rsp("cas_ok", 32'd1);
    do_read("cas_ok_read", 32'h20, 32'd9);
    send_beat(1'b0, 1'b1, 32'h20, 32'd5);
    send_beat(1'b0, 1'b1, 32'h20, 32'd7);
    get_rsp("cas_fail", 32'd0);
    do_read("cas_fail_read", 32'h20, 32'd9);

    // Response back-pressure with a second request waiting.
    send_beat(1'b0, 1'b0, 32'h20, 32'h0);
    wait_n = 0;
    while (!bus.mem_rsp_val_o && wait_n < BOUND) begin
      @(negedge clk);
      wait_n++;
    end
    check("stall_first_lat", wait_n, LATENCY);
    bus.mem_req_val_i  = 1'b1;
    bus.mem_req_addr_i = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_val", {31'b0, bus.mem_rsp_val_o}, 32'd1);
      check("stall_rsp_data", bus.mem_rsp_data_o, 32'd9);
      check("stall_req_rdy", {31'b0, bus.mem_req_rdy_o}, 32'd0);
    end
    bus.mem_rsp_rdy_i = 1'b1;
    @(negedge clk);
    bus.mem_rsp_rdy_i = 1'b0;
    check("release_req_rdy", {31'b0, bus.mem_req_rdy_o}, 32'd1);
    check("release_rsp_val", {31'b0, bus.mem_rsp_val_o}, 32'd0);
    @(negedge clk);
    bus.mem_req_val_i = 1'b0;
    get_rsp("stall_second", 32'hDEAD_BEEF);

    // CAS beat 0 followed by a plain read: protocol error, no response.
    send_beat(1'b0, 1'b1, 32'h20, 32'd9);
    check("perr_before", {31'b0, proto_err}, 32'd0);
    send_beat(1'b0, 1'b0, 32'h20, 32'h0);
    check("perr_set", {31'b0, proto_err}, 32'd1);
    check("perr_req_rdy", {31'b0, bus.mem_req_rdy_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("perr_no_rsp", {31'b0, bus.mem_rsp_val_o}, 32'd0);
      @(negedge clk);
    end
    do_read("perr_mem", 32'h20, 32'd9);
    check("perr_sticky", {31'b0, proto_err}, 32'd1);

    // Reset while BUSY.
    send_beat(1'b0, 1'b0, 32'h10, 32'h0);
    check("busy_state_rdy", {31'b0, bus.mem_req_rdy_o}, 32'd0);
    reset_pulse("rst_busy");
    do_read("rst_busy_mem4", 32'h10, 32'h0);
    do_read("rst_busy_mem8", 32'h20, 32'h0);

    // Reset while RSP is pending.
    send_beat(1'b1, 1'b0, 32'h30, 32'hCAFE);
    get_rsp("pre_rsp_wr", 32'hCAFE);
    send_beat(1'b0, 1'b0, 32'h30, 32'h0);
    wait_n = 0;
    while (!bus.mem_rsp_val_o && wait_n < BOUND) begin
      @(negedge clk);
      wait_n++;
    end
    check("rsp_state_val", {31'b0, bus.mem_rsp_val_o}, 32'd1);
    reset_pulse("rst_rsp");
    do_read("rst_rsp_mem12", 32'h30, 32'h0);
    do_read("rst_rsp_wrap", 32'h30 + 4 * DEPTH, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
